// File: rtl/uart_cmd_parser.sv
// Frame parser behind the UART receiver: SYNC, CMD, LEN, payload, XOR checksum.
// Presents each validated command as one parallel word with a valid/ready handshake.
module uart_cmd_parser #(
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100_000,
  parameter int          LEN_W          = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk_i,
  input  logic                   arstn_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic [7:0]             cmd_o,
  output logic [LEN_W-1:0]       len_o,
  output logic [8*MAX_LEN-1:0]   payload_o,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic                   err_o,
  output logic [1:0]             err_code_o
);

  localparam int               TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, CHK, OUT} state_t;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  state_t                 state_r, state_s;
  logic                   accept_s, in_frame_s, timeout_s;
  logic                   err_s;
  logic [1:0]             err_code_s;
  logic [TO_W-1:0]        idle_cnt_r;
  logic [7:0]             chk_r;
  logic [LEN_W-1:0]       idx_r;
  logic [7:0]             cmd_r;
  logic [LEN_W-1:0]       len_r;
  logic [8*MAX_LEN-1:0]   payload_r;
  logic                   cmd_valid_r;
  logic                   err_r;
  logic [1:0]             err_code_r;

  assign byte_ready_o = (state_r != OUT);
  assign accept_s     = byte_valid_i && byte_ready_o;
  assign in_frame_s   = state_r inside {CMD, LEN, DATA, CHK};
  assign timeout_s    = in_frame_s && !accept_s && (idle_cnt_r == TO_LAST);

  assign cmd_o        = cmd_r;
  assign len_o        = len_r;
  assign payload_o    = payload_r;
  assign cmd_valid_o  = cmd_valid_r;
  assign err_o        = err_r;
  assign err_code_o   = err_code_r;

  // State register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and error-event decode; a timeout loses to a byte accepted the same cycle
  always_comb begin
    state_s    = state_r;
    err_s      = 1'b0;
    err_code_s = 2'd0;
    if (timeout_s) begin
      state_s    = IDLE;
      err_s      = 1'b1;
      err_code_s = 2'd3;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (byte_i == SYNC_BYTE)) state_s = CMD;
          else                                   state_s = IDLE;
        end
        CMD: begin
          if (accept_s) state_s = LEN;
          else          state_s = CMD;
        end
        LEN: begin
          if (accept_s) begin
            if (byte_i > MAX_LEN_B) begin
              state_s    = IDLE;
              err_s      = 1'b1;
              err_code_s = 2'd2;
            end else if (byte_i == 8'd0) begin
              state_s = CHK;
            end else begin
              state_s = DATA;
            end
          end else begin
            state_s = LEN;
          end
        end
        DATA: begin
          if (accept_s && ((idx_r + LEN_W'(1)) == len_r)) state_s = CHK;
          else                                            state_s = DATA;
        end
        CHK: begin
          if (accept_s) begin
            if (byte_i == chk_r) begin
              state_s = OUT;
            end else begin
              state_s    = IDLE;
              err_s      = 1'b1;
              err_code_s = 2'd1;
            end
          end else begin
            state_s = CHK;
          end
        end
        OUT: begin
          if (cmd_ready_i) state_s = IDLE;
          else             state_s = OUT;
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // Status outputs and inter-byte idle counter
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cmd_valid_r <= 1'b0;
      err_r       <= 1'b0;
      err_code_r  <= 2'd0;
      idle_cnt_r  <= '0;
    end else begin
      cmd_valid_r <= (state_s == OUT);
      err_r       <= err_s;
      if (err_s) err_code_r <= err_code_s;
      else       err_code_r <= err_code_r;
      if (accept_s || !in_frame_s || timeout_s) idle_cnt_r <= '0;
      else                                      idle_cnt_r <= idle_cnt_r + TO_W'(1);
    end
  end

  // Frame datapath: opcode, length, payload bytes and running checksum
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cmd_r     <= 8'd0;
      len_r     <= '0;
      payload_r <= '0;
      chk_r     <= 8'd0;
      idx_r     <= '0;
    end else if (accept_s) begin
      case (state_r)
        IDLE: begin
          if (byte_i == SYNC_BYTE) begin
            payload_r <= '0;
            chk_r     <= 8'd0;
            idx_r     <= '0;
          end
        end
        CMD: begin
          cmd_r <= byte_i;
          chk_r <= byte_i;
        end
        LEN: begin
          chk_r <= chk_update(chk_r, byte_i);
          idx_r <= '0;
          if (byte_i <= MAX_LEN_B) len_r <= byte_i[LEN_W-1:0];
        end
        DATA: begin
          payload_r[{idx_r, 3'b000} +: 8] <= byte_i;
          chk_r <= chk_update(chk_r, byte_i);
          idx_r <= idx_r + LEN_W'(1);
        end
        default: begin
          chk_r <= chk_r;
        end
      endcase
    end
  end

endmodule
